// File: rtl/instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
// instr_fetch_buffer : owns the fetch PC, prefetches words from imem into a
// small PC-tagged FIFO and hands one instruction per cycle to fetch/decode.
// Optional macro IFB_BYPASS_EN: zero-latency bypass of a response into an
// empty FIFO.                                          Revision 1.0
// ============================================================================
module instr_fetch_buffer #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        srst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_f,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] pc_plus4_f
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      data_mem_q [DEPTH];
    logic [31:0]      pc_mem_q   [DEPTH];

    logic             w_accept;
    logic             w_rsp;
    logic             w_rsp_keep;
    logic             w_bypass;
    logic             w_fifo_valid;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W:0]   w_credit_used;
    logic [31:0]      w_redirect_pc;
    logic [CNT_W-1:0] w_inflight_after;
    logic             w_unused_ok;

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_unused_ok   = ^redirect_pc[1:0];

    // Credit rule: in-flight requests plus buffered entries never exceed DEPTH,
    // so every response is guaranteed a FIFO slot.
    assign w_credit_used  = {1'b0, outstanding_q} + {1'b0, count_q};
    assign imem_req_valid = (state_q != S_BOOT) && (w_credit_used < {1'b0, DEPTH_C});
    assign imem_req_addr  = fetch_pc_q;
    assign w_accept       = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding (e.g. right after reset) are ignored.
    assign w_rsp      = imem_rsp_valid && (outstanding_q != '0);
    assign w_rsp_keep = w_rsp && !redirect_valid && (discard_q == '0);

`ifdef IFB_BYPASS_EN
    assign w_bypass = w_rsp_keep && (count_q == '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_fifo_valid     = (count_q != '0);
    assign w_pop            = w_fifo_valid && !stall_f && !redirect_valid;
    assign w_push           = w_rsp_keep && !(w_bypass && !stall_f);
    assign w_inflight_after = outstanding_q + CNT_W'(w_accept) - CNT_W'(w_rsp);

    always_comb begin
        outstanding_d = w_inflight_after;
        discard_d     = discard_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        if (redirect_valid) begin
            // Everything still in flight belongs to the wrong path.
            discard_d  = w_inflight_after;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = w_redirect_pc;
            rsp_pc_d   = w_redirect_pc;
        end else begin
            if (w_rsp && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if (w_accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (w_rsp_keep) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (redirect_valid && (discard_d != '0)) state_d = S_DRAIN;
            S_DRAIN: if (discard_d == '0) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q       <= S_BOOT;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            data_mem_q[wr_ptr_q] <= imem_rsp_data;
            pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    // When nothing is valid, pc_f shows the PC of the next expected response.
    always_comb begin
        instr_valid = 1'b0;
        instr_f     = NOP_INSTR;
        pc_f        = rsp_pc_q;
        if (w_fifo_valid) begin
            instr_valid = 1'b1;
            instr_f     = data_mem_q[rd_ptr_q];
            pc_f        = pc_mem_q[rd_ptr_q];
        end else if (w_bypass) begin
            instr_valid = 1'b1;
            instr_f     = imem_rsp_data;
            pc_f        = rsp_pc_q;
        end
    end

    assign pc_plus4_f = pc_f + 32'd4;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (srst_n && w_push) begin
            assert (count_q != DEPTH_C)
            else $error("instr_fetch_buffer: push into full FIFO");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_buffer : directed self-checking bench for instr_fetch_buffer
// with a small fixed-latency memory model returning the address as data.
// Revision 1.0
// ============================================================================
module tb_instr_fetch_buffer;

`ifdef IFB_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic        clk;
    logic        srst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_f;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;

    int          n_cmp;
    int          n_err;
    int          mem_lat;
    logic        pv [4];
    logic [31:0] pa [4];

    instr_fetch_buffer #(
        .DEPTH     (4),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .srst_n         (srst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_f        (stall_f),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_f        (instr_f),
        .pc_f           (pc_f),
        .pc_plus4_f     (pc_plus4_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample acceptance before the edge, then drive the response
    // for the request accepted mem_lat edges ago.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        @(posedge clk);
        #1;
        for (int i = 3; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = acc;
        pa[0] = a;
        imem_rsp_valid = pv[mem_lat-1];
        imem_rsp_data  = pa[mem_lat-1];
        #1;
    endtask

    task automatic do_reset(input int l);
        srst_n         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall_f        = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        mem_lat        = l;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0;
            pa[i] = 32'h0;
        end
        tick();
        tick();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
        chk({tag, "_req_addr"},  imem_req_addr,       32'h0);
        chk({tag, "_valid"},     32'(instr_valid),    32'h0);
        chk({tag, "_instr"},     instr_f,             32'h0000_0013);
        chk({tag, "_pc"},        pc_f,                32'h0);
        chk({tag, "_pc4"},       pc_plus4_f,          32'h4);
    endtask

    // Expects srst_n just released, 1-cycle memory, no stall.
    task automatic boot_seq(input string tag);
        tick();
        chk({tag, "_e0_valid"},     32'(instr_valid),    32'h0);
        chk({tag, "_e0_req_valid"}, 32'(imem_req_valid), 32'h1);
        chk({tag, "_e0_req_addr"},  imem_req_addr,       32'h0);
        for (int i = 0; i < LAT - 2; i++) begin
            tick();
            chk({tag, "_early_valid"}, 32'(instr_valid), 32'h0);
            chk({tag, "_req_addr4"},   imem_req_addr,    32'h4);
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            chk({tag, "_seq_valid"}, 32'(instr_valid), 32'h1);
            chk({tag, "_seq_pc"},    pc_f,             32'(4 * j));
            chk({tag, "_seq_instr"}, instr_f,          32'(4 * j));
            chk({tag, "_seq_pc4"},   pc_plus4_f,       32'(4 * j + 4));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset values and first fetch sequence
        do_reset(1);
        chk_reset_values("rst");
        srst_n = 1'b1;
        boot_seq("boot");

        // Long stall fills the FIFO, then drains with no gap
        do_reset(1);
        stall_f = 1'b1;
        srst_n  = 1'b1;
        repeat (10) tick();
        chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
        chk("stall_valid",     32'(instr_valid),    32'h1);
        chk("stall_pc",        pc_f,                32'h0);
        chk("stall_instr",     instr_f,             32'h0);
        stall_f = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk("drain_valid", 32'(instr_valid), 32'h1);
            chk("drain_pc",    pc_f,             32'(4 * j));
            chk("drain_instr", instr_f,          32'(4 * j));
        end

        // Memory not ready: pending request address holds
        do_reset(1);
        stall_f = 1'b1;
        srst_n  = 1'b1;
        repeat (10) tick();
        imem_req_ready = 1'b0;
        stall_f        = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("nrdy_req_valid", 32'(imem_req_valid), 32'h1);
            chk("nrdy_req_addr",  imem_req_addr,       32'h10);
        end
        chk("nrdy_empty", 32'(instr_valid), 32'h0);
        imem_req_ready = 1'b1;
        repeat (LAT - 1) tick();
        chk("nrdy_resume_valid", 32'(instr_valid), 32'h1);
        chk("nrdy_resume_pc",    pc_f,             32'h10);
        chk("nrdy_resume_instr", instr_f,          32'h10);

        // Redirect with three requests in flight on a 3-cycle memory
        do_reset(3);
        srst_n = 1'b1;
        repeat (3) tick();
        chk("redir_pre_addr", imem_req_addr, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        chk("redir_req_addr",  imem_req_addr,       32'h100);
        chk("redir_req_valid", 32'(imem_req_valid), 32'h1);
        chk("redir_valid0",    32'(instr_valid),    32'h0);
        tick();
        chk("redir_drop1", 32'(instr_valid), 32'h0);
        tick();
        chk("redir_drop2", 32'(instr_valid), 32'h0);
        tick();
`ifndef IFB_BYPASS_EN
        chk("redir_drop3", 32'(instr_valid), 32'h0);
        tick();
`endif
        chk("redir_first_valid", 32'(instr_valid), 32'h1);
        chk("redir_first_pc",    pc_f,             32'h100);
        chk("redir_first_pc4",   pc_plus4_f,       32'h104);
        chk("redir_first_instr", instr_f,          32'h100);

        // Redirect coinciding with a pop and a response
        do_reset(1);
        srst_n = 1'b1;
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("coll_empty",    32'(instr_valid), 32'h0);
        chk("coll_req_addr", imem_req_addr,    32'h200);
        tick();
`ifndef IFB_BYPASS_EN
        chk("coll_stale_drop", 32'(instr_valid), 32'h0);
        tick();
`endif
        chk("coll_first_valid", 32'(instr_valid), 32'h1);
        chk("coll_first_pc",    pc_f,             32'h200);
        chk("coll_first_instr", instr_f,          32'h200);

        // Asynchronous reset pulse between clock edges
        do_reset(1);
        srst_n = 1'b1;
        repeat (5) tick();
        srst_n = 1'b0;
        #1;
        chk_reset_values("arst");
        #1;
        srst_n = 1'b1;
        boot_seq("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- Prefetch buffer between the instruction memory port and the pipeline fetch stage.
- Owns the fetch PC and issues in-order word requests to instruction memory.
- Queues returned instructions with their PCs in a small FIFO and presents one per cycle to fetch/decode.
- Honours the hazard unit's stall_f; flushes on an execute-stage redirect (pcsrc_e / pc_target_e), discarding responses still in flight.

Parameters:
- DEPTH, 4: FIFO entries; also the cap on (outstanding requests + occupancy). Power of two, ≥2.
- RESET_PC, 32'h0000_0000: fetch PC after reset.
- NOP_INSTR, 32'h0000_0013: value driven on instr_f when no valid instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge
- srst_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  branch/jump taken in execute (pcsrc_e)
- redirect_pc  in  32  redirect target (pc_target_e); bits [1:0] ignored, treated as 0
- stall_f  in  1  consumer stall; no pop while high
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned request address
- imem_rsp_valid  in  1  response valid (in order, ≥1 cycle after accept, never back-pressured)
- imem_rsp_data  in  32  response instruction word
- instr_valid  out  1  instr_f/pc_f hold a real instruction
- instr_f  out  32  instruction at FIFO head, NOP_INSTR when invalid
- pc_f  out  32  PC of instr_f
- pc_plus4_f  out  32  pc_f + 4 (mod 2^32)

Behaviour:
- Reset (srst_n low, async): FIFO empty, outstanding=0, discard_cnt=0, fetch_pc=RESET_PC, state=S_BOOT. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr_f=NOP_INSTR, pc_f=RESET_PC, pc_plus4_f=RESET_PC+4. Reset mid-transaction drops everything; responses arriving in the first cycle after release are ignored (outstanding=0).
- FSM:
  - S_BOOT: one idle cycle after reset release, then S_RUN.
  - S_RUN: on redirect_valid with nonzero in-flight requests → S_DRAIN; otherwise stay.
  - S_DRAIN: when discard_cnt reaches 0 → S_RUN; another redirect reloads discard_cnt.
- Request issue (S_RUN/S_DRAIN): imem_req_valid=1 when outstanding + occupancy < DEPTH. Address = fetch_pc. On accept (valid&&ready): outstanding+1, fetch_pc+=4 (wraps at 2^32).
  - Once valid is asserted, addr stays stable until accepted. Only exception: a redirect may retarget an unaccepted request to redirect_pc in the next cycle.
- Response: outstanding−1 on each imem_rsp_valid.
  - discard_cnt>0: data dropped, discard_cnt−1.
  - Otherwise: {data, pc} pushed; PC comes from an internal response-PC counter that tracks in-order accepted addresses.
  - Overflow is impossible by the credit rule; a push into a full FIFO is an assertion failure.
- Pop: instr_valid && !stall_f at the clock edge removes the head. Outputs are combinational from the FIFO head. Latency from response to instr_valid: 1 cycle.
- Redirect (redirect_valid=1, highest priority):
  - Same edge: FIFO cleared, any pop that cycle ignored, fetch_pc and response-PC counter ← {redirect_pc[31:2],2'b00}.
  - discard_cnt ← outstanding + (req accepted this cycle) − (rsp this cycle).
  - A response arriving in the redirect cycle is dropped.
  - instr_valid=0 in the cycle after redirect.
- stall_f with redirect: redirect still takes effect.
- Pointers wrap modulo DEPTH. Full = occupancy==DEPTH; empty = occupancy==0.

Optional Feature:
- Macro IFB_BYPASS_EN.
- Defined: when the FIFO is empty, discard_cnt==0, no redirect and imem_rsp_valid=1, the response is driven combinationally onto instr_f/pc_f with instr_valid=1 in the same cycle. If !stall_f it is consumed without a push; otherwise it is pushed. Response latency is 0 cycles.
- Undefined: all responses pass through the FIFO, 1-cycle latency.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning addr as data → requests 0x0,0x4,0x8…; instr_valid first high 3 cycles after release (2 with IFB_BYPASS_EN); pc_f/instr_f = 0x0/0x0, then 0x4/0x4, one per cycle.
- stall_f held high for 10 cycles → exactly DEPTH=4 instructions buffered plus 0 outstanding; imem_req_valid=0; on release, pops 0x0..0xC in order with no gap.
- imem_req_ready=0 for 5 cycles with req pending → imem_req_addr stable at 0x10; no outstanding increment.
- 3-cycle memory latency, 3 requests in flight, redirect to 0x103 → next request addr 0x100; the 3 stale responses are dropped; first instr_valid has pc_f=0x100, pc_plus4_f=0x104.
- Redirect in the same cycle as a pop and a response → FIFO empty next cycle; response discarded; discard_cnt excludes it.
- Async srst_n pulse mid-fetch between clock edges → outputs immediately at reset values; restart from RESET_PC.
